// File: rtl/cdc_reg_bridge.sv
// Byte-command decoder between the usb_cdc streams and a small register bus.
// Optional macro CDC_REG_BRIDGE_WACK_EN: successful writes answer with ACK (0x06).
module cdc_reg_bridge #(
   parameter int         ADDR_W         = 4,
   parameter int         TIMEOUT_CYCLES = 48000,
   parameter logic [7:0] ID_BYTE        = 8'hA5
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [7:0]        out_data_i,
   input  logic              out_valid_i,
   output logic              out_ready_o,
   output logic [7:0]        in_data_o,
   output logic              in_valid_o,
   input  logic              in_ready_i,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [7:0]        reg_wdata_o,
   output logic              reg_we_o,
   output logic              reg_re_o,
   input  logic [7:0]        reg_rdata_i,
   output logic              timeout_o,
   output logic [2:0]        dbg_state_o
);

   // Both streams: a byte moves on a rising edge where valid && ready; the
   // IN side holds in_data_o stable while in_valid_o is high and not accepted.

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_ADDR = 3'd1,
      GET_DATA = 3'd2,
      WRITE    = 3'd3,
      READ     = 3'd4,
      RDWAIT   = 3'd5,
      RESP     = 3'd6
   } state_t;

   localparam logic [7:0] OP_W = 8'h57;
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_I = 8'h3F;
   localparam logic [7:0] NAK  = 8'h15;
   localparam logic [7:0] ACK  = 8'h06;

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t            state_q, state_d;
   logic [7:0]        in_data_q, in_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              is_wr_q, is_wr_d;
   logic              bad_q, bad_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              accept;
   logic              addr_bad;
   logic              tmo_hit;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         in_data_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         bad_q     <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_data_q <= in_data_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         bad_q     <= bad_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign out_ready_o = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
   assign accept      = out_valid_i && out_ready_o;
   assign addr_bad    = (8'(out_data_i >> ADDR_W) != 8'd0);
   assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      in_data_d = in_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_wr_d   = is_wr_q;
      bad_d     = bad_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               case (out_data_i)
                  OP_W:    begin is_wr_d = 1'b1; bad_d = 1'b0; state_d = GET_ADDR; end
                  OP_R:    begin is_wr_d = 1'b0; bad_d = 1'b0; state_d = GET_ADDR; end
                  OP_I:    begin in_data_d = ID_BYTE; state_d = RESP; end
                  default: begin in_data_d = NAK; state_d = RESP; end
               endcase
            end
         end
         GET_ADDR, GET_DATA: begin
            if (accept) begin
               // An accepted byte wins over a timeout expiring on the same edge.
               cnt_d = '0;
               if (state_q == GET_ADDR) begin
                  if (addr_bad) begin
                     if (is_wr_q) begin
                        bad_d   = 1'b1;
                        state_d = GET_DATA;
                     end else begin
                        in_data_d = NAK;
                        state_d   = RESP;
                     end
                  end else begin
                     addr_d  = out_data_i[ADDR_W-1:0];
                     state_d = is_wr_q ? GET_DATA : READ;
                  end
               end else begin
                  wdata_d = out_data_i;
                  if (bad_q) begin
                     in_data_d = NAK;
                     state_d   = RESP;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end else if (tmo_hit) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRITE: begin
`ifdef CDC_REG_BRIDGE_WACK_EN
            in_data_d = ACK;
            state_d   = RESP;
`else
            state_d   = IDLE;
`endif
         end
         READ:   state_d = RDWAIT;
         RDWAIT: begin
            in_data_d = reg_rdata_i;
            state_d   = RESP;
         end
         RESP: if (in_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_data_o   = in_data_q;
   assign in_valid_o  = (state_q == RESP);
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_we_o    = (state_q == WRITE);
   assign reg_re_o    = (state_q == READ);
   assign timeout_o   = timeout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cdc_reg_bridge.sv
// Directed bench for cdc_reg_bridge with a short timeout and a small register model.
module tb_cdc_reg_bridge;

   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic [7:0] out_data_i = '0;
   logic       out_valid_i = 1'b0;
   logic       out_ready_o;
   logic [7:0] in_data_o;
   logic       in_valid_o;
   logic       in_ready_i = 1'b0;
   logic [3:0] reg_addr_o;
   logic [7:0] reg_wdata_o;
   logic       reg_we_o;
   logic       reg_re_o;
   logic [7:0] reg_rdata_i = '0;
   logic       timeout_o;
   logic [2:0] dbg_state_o;

   int total = 0;
   int bad = 0;

   logic [7:0] mem [16];

   cdc_reg_bridge #(.ADDR_W(4), .TIMEOUT_CYCLES(16), .ID_BYTE(8'hA5)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .out_data_i  (out_data_i),
      .out_valid_i (out_valid_i),
      .out_ready_o (out_ready_o),
      .in_data_o   (in_data_o),
      .in_valid_o  (in_valid_o),
      .in_ready_i  (in_ready_i),
      .reg_addr_o  (reg_addr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_we_o    (reg_we_o),
      .reg_re_o    (reg_re_o),
      .reg_rdata_i (reg_rdata_i),
      .timeout_o   (timeout_o),
      .dbg_state_o (dbg_state_o)
   );

   always #5 clk_i = ~clk_i;

   // Register model: address 7 is a fixed 0xC3 status register.
   always @(posedge clk_i) begin
      if (reg_we_o) mem[reg_addr_o] <= reg_wdata_o;
      if (reg_re_o) reg_rdata_i <= (reg_addr_o == 4'd7) ? 8'hC3 : mem[reg_addr_o];
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Returns one tick after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      int   n;
      out_data_i  = b;
      out_valid_i = 1'b1;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 50) begin
         rdy = out_ready_o;
         @(posedge clk_i);
         #1;
         n++;
      end
      out_valid_i = 1'b0;
      if (!rdy) chk("send_timeout", 8'd0, 8'd1);
   endtask

   task automatic take_resp(input string tag, input logic [7:0] exp);
      chk({tag, "_valid"}, {7'd0, in_valid_o}, 8'd1);
      chk({tag, "_data"}, in_data_o, exp);
      in_ready_i = 1'b1;
      step(1);
      in_ready_i = 1'b0;
      chk({tag, "_done"}, {7'd0, in_valid_o}, 8'd0);
   endtask

   initial begin
      #3;
      chk("rst_in_valid", {7'd0, in_valid_o}, 8'd0);
      chk("rst_in_data", in_data_o, 8'h00);
      chk("rst_addr", {4'd0, reg_addr_o}, 8'h00);
      chk("rst_wdata", reg_wdata_o, 8'h00);
      chk("rst_we_re_to", {5'd0, reg_we_o, reg_re_o, timeout_o}, 8'd0);
      chk("rst_ready", {7'd0, out_ready_o}, 8'd1);
      step(2);
      rstn_i = 1'b1;
      step(2);

      // Write 0x5A to register 3.
      send_byte(8'h57);
      send_byte(8'h03);
      chk("wr_we_early", {7'd0, reg_we_o}, 8'd0);
      send_byte(8'h5A);
      chk("wr_we", {7'd0, reg_we_o}, 8'd1);
      chk("wr_addr", {4'd0, reg_addr_o}, 8'h03);
      chk("wr_wdata", reg_wdata_o, 8'h5A);
      step(1);
      chk("wr_we_off", {7'd0, reg_we_o}, 8'd0);
`ifdef CDC_REG_BRIDGE_WACK_EN
      take_resp("wr_ack", 8'h06);
`else
      chk("wr_no_resp", {7'd0, in_valid_o}, 8'd0);
      step(2);
      chk("wr_no_resp2", {7'd0, in_valid_o}, 8'd0);
`endif

      // Read register 7: strobe one cycle after address, data three cycles after.
      send_byte(8'h52);
      send_byte(8'h07);
      chk("rd_re", {7'd0, reg_re_o}, 8'd1);
      chk("rd_addr", {4'd0, reg_addr_o}, 8'h07);
      chk("rd_valid_n1", {7'd0, in_valid_o}, 8'd0);
      step(1);
      chk("rd_re_off", {7'd0, reg_re_o}, 8'd0);
      chk("rd_valid_n2", {7'd0, in_valid_o}, 8'd0);
      step(1);
      take_resp("rd7", 8'hC3);

      // Read back register 3.
      send_byte(8'h52);
      send_byte(8'h03);
      step(2);
      take_resp("rd3", 8'h5A);

      // Bad read address.
      send_byte(8'h52);
      send_byte(8'h20);
      chk("badrd_re", {7'd0, reg_re_o}, 8'd0);
      take_resp("badrd", 8'h15);

      // Bad write address: all three bytes consumed, no strobe.
      send_byte(8'h57);
      send_byte(8'h10);
      chk("badwr_ready", {7'd0, out_ready_o}, 8'd1);
      send_byte(8'h11);
      chk("badwr_we", {7'd0, reg_we_o}, 8'd0);
      take_resp("badwr", 8'h15);

      // Unknown opcode.
      send_byte(8'h00);
      take_resp("unk", 8'h15);

      // Identify with back-pressure.
      send_byte(8'h3F);
      for (int i = 0; i < 10; i++) begin
         chk("id_hold_valid", {7'd0, in_valid_o}, 8'd1);
         chk("id_hold_data", in_data_o, 8'hA5);
         chk("id_hold_ready", {7'd0, out_ready_o}, 8'd0);
         step(1);
      end
      take_resp("id", 8'hA5);

      // Timeout: 16 idle cycles after the opcode drop the command.
      send_byte(8'h57);
      for (int i = 1; i < 16; i++) begin
         step(1);
         chk("to_early", {7'd0, timeout_o}, 8'd0);
      end
      step(1);
      chk("to_pulse", {7'd0, timeout_o}, 8'd1);
      chk("to_idle", {5'd0, dbg_state_o}, 8'd0);
      step(1);
      chk("to_pulse_end", {7'd0, timeout_o}, 8'd0);
      chk("to_no_resp", {7'd0, in_valid_o}, 8'd0);
      send_byte(8'h3F);
      take_resp("to_id", 8'hA5);

      // A byte accepted on the expiring edge keeps the command alive.
      send_byte(8'h57);
      step(15);
      send_byte(8'h05);
      chk("edge_no_to", {7'd0, timeout_o}, 8'd0);
      chk("edge_state", {5'd0, dbg_state_o}, 8'd2);
      send_byte(8'h33);
      chk("edge_we", {7'd0, reg_we_o}, 8'd1);
      chk("edge_addr", {4'd0, reg_addr_o}, 8'h05);
      chk("edge_wdata", reg_wdata_o, 8'h33);
      step(1);
`ifdef CDC_REG_BRIDGE_WACK_EN
      take_resp("edge_ack", 8'h06);
`endif

      // Reset while a response is pending.
      send_byte(8'h3F);
      chk("rst_resp_pend", {7'd0, in_valid_o}, 8'd1);
      rstn_i = 1'b0;
      #1;
      chk("rst_async_valid", {7'd0, in_valid_o}, 8'd0);
      chk("rst_async_data", in_data_o, 8'h00);
      step(1);
      rstn_i = 1'b1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_ready", {7'd0, out_ready_o}, 8'd1);
         chk("post_rst_valid", {7'd0, in_valid_o}, 8'd0);
         step(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
